// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the control state encoding and counter sizing helper.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial bit-slice.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full adder slice.
// Signed overflow output is built only with SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic fa_sum;
  logic fa_cout;
  logic last;

  assign last = (cnt_q == LAST);

  full_adder u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    dsr_d    = dsr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        dsr_d   = {fa_sum, dsr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        diff_d   = dsr_q;
        borrow_d = ~carry_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
    // busy covers the done cycle even though control is already idle
    busy_d = (state_d != IDLE) | done_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      dsr_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      dsr_q    <= dsr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;

  // carry into MSB xor carry out of MSB, latched on the final slice
  always_comb begin
    flag_d = flag_q;
    ovf_d  = ovf_q;
    if (state_q == SHIFT && last) begin
      flag_d = carry_q ^ fa_cout;
    end
    if (state_q == DONE) begin
      ovf_d = flag_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor, WIDTH=8.
// Expected values are hand-computed differences and cycle counts.
module tb_serial_subtractor;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  int n;
  int pulses;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  localparam logic [31:0] OVF_80_01 = 32'd1;
`else
  localparam logic [31:0] OVF_80_01 = 32'd0;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one start cycle; returns just after the accept edge
  task automatic go(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    a = 8'hxx;
    b = 8'hxx;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    step();

    go(8'h05, 8'h03);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_diff_hold", 32'(diff), 32'h00);
    wait_done(n);
    check("t1_lat", 32'(n), 32'd9);
    check("t1_diff", 32'(diff), 32'h02);
    check("t1_borrow", 32'(borrow), 32'd0);
    check("t1_ovf", 32'(ovf), 32'd0);
    check("t1_busy_done", 32'(busy), 32'd1);
    step();
    check("t1_done_fall", 32'(done), 32'd0);
    check("t1_busy_fall", 32'(busy), 32'd0);

    go(8'h03, 8'h05);
    wait_done(n);
    check("t2_lat", 32'(n), 32'd9);
    check("t2_diff", 32'(diff), 32'hFE);
    check("t2_borrow", 32'(borrow), 32'd1);
    check("t2_ovf", 32'(ovf), 32'd0);
    step();

    go(8'h80, 8'h01);
    wait_done(n);
    check("t3_diff", 32'(diff), 32'h7F);
    check("t3_borrow", 32'(borrow), 32'd0);
    check("t3_ovf", 32'(ovf), OVF_80_01);
    step();

    a = 8'h00;
    b = 8'h00;
    start = 1'b1;
    step();
    a = 8'h00;
    b = 8'h01;
    wait_done(n);
    check("t4_lat", 32'(n), 32'd9);
    check("t4_diff", 32'(diff), 32'h00);
    check("t4_borrow", 32'(borrow), 32'd0);
    step();
    start = 1'b0;
    check("t4_b2b_busy", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 30) begin
      step();
      n++;
    end
    check("t4_b2b_gap", 32'(n), 32'd10);
    check("t4_wrap_diff", 32'(diff), 32'hFF);
    check("t4_wrap_borrow", 32'(borrow), 32'd1);
    step();

    go(8'h10, 8'h01);
    repeat (2) step();
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 3;
    while (!done && n < 30) begin
      step();
      n++;
    end
    check("t5_lat", 32'(n), 32'd9);
    check("t5_diff", 32'(diff), 32'h0F);
    check("t5_borrow", 32'(borrow), 32'd0);
    pulses = 0;
    repeat (15) begin
      step();
      if (done) pulses++;
    end
    check("t5_extra_done", 32'(pulses), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);

    go(8'h20, 8'h01);
    repeat (4) step();
    rstn = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_diff", 32'(diff), 32'h00);
    pulses = 0;
    repeat (12) begin
      step();
      if (done) pulses++;
    end
    check("t6_no_done", 32'(pulses), 32'd0);
    rstn = 1'b1;
    step();
    go(8'h44, 8'h11);
    wait_done(n);
    check("t6_lat", 32'(n), 32'd9);
    check("t6_diff", 32'(diff), 32'h33);
    check("t6_borrow", 32'(borrow), 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing diff = a − b LSB-first, one bit per clock, through a single 1-bit full adder. It computes a + ~b + 1 with the carry held in a flop between cycles. It is the inverse-operation companion to the 1-bit adder work in the workshop datapath, and trades latency for a single full-adder cell. A start/busy/done handshake delivers results to a parallel consumer.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- busy  output  1  high while in SHIFT or DONE
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow  output  1  1 when a < b (unsigned), i.e. inverted final carry
- ovf  output  1  signed overflow (see Configuration)

## Operation
- Clock is clk. Reset rstn is asynchronous and active-low.
- Reset state: IDLE. All internal registers are 0. Outputs: busy=0, done=0, diff=0, borrow=0, ovf=0.
- States:
  - IDLE → SHIFT on start=1. Actions: a_sr←a, b_sr←~b, carry←1, cnt←0.
  - SHIFT, each cycle:
    - Full adder inputs: (a_sr[0], b_sr[0], carry).
    - Sum bit shifts into diff_sr MSB; diff_sr shifts right.
    - a_sr and b_sr shift right; carry←c_out; cnt++.
    - Exit to DONE after cnt reaches WIDTH−1.
  - DONE: diff←diff_sr, borrow←~carry, ovf←flag. done=1 for exactly this cycle. Unconditionally → IDLE.
- start in SHIFT or DONE is ignored. There is no queueing.
- diff, borrow and ovf hold their values until the next DONE. They do not change when start is accepted.
- a and b are don't-care except in the cycle start is accepted.
- Reset asserted mid-operation aborts the operation immediately: state goes to IDLE, outputs go to reset values, no done pulse.
- Unsigned wrap: a=0, b=1 gives diff=all-ones, borrow=1.

## Timing
- Start accepted at rising edge T0 (IDLE, start=1). busy=1 from T0+.
- SHIFT occupies edges T0+1 … T0+WIDTH. DONE is entered at edge T0+WIDTH.
- done=1 and the new diff/borrow/ovf are visible in the cycle after edge T0+WIDTH+1.
  - Result registers update on entry to DONE output; done is registered.
  - Latency start→done = WIDTH+1 cycles.
- busy falls in the same edge that done falls.
- Earliest next start accepted: the edge after done deasserts.
- Back-to-back throughput: one result per WIDTH+2 cycles.
- done, busy and diff are all registered. There are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUBTRACTOR_OVF_EN defined:
  - ovf is updated at DONE as the carry-in to the MSB XOR the carry-out of the MSB, i.e. the last SHIFT cycle's carry XOR c_out.
  - Meaning: signed two's-complement overflow.
- Not defined:
  - The ovf port remains, tied to 0.
  - No extra flops are synthesised.

## Structure
- Package serial_subtractor_pkg holds:
  - the state enum typedef (IDLE, SHIFT, DONE), 2-bit;
  - the counter-width function $clog2(WIDTH).
- Sub-module: the existing full_adder, instantiated once as the bit-slice. Ports: a, b, c_in → sum, c_out.

## Test plan
- WIDTH=8. start with a=0x05, b=0x03 → done exactly 9 cycles after accept; diff=0x02, borrow=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, borrow=1, ovf=0.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1. Without the macro: ovf=0 for the same inputs.
- a=0x00, b=0x00 → diff=0x00, borrow=0. Then back-to-back start held high → second done 10 cycles after the first.
- Start with a=0x10, b=0x01. Pulse start with a=0xFF, b=0xFF during SHIFT → the pulse is ignored; diff=0x0F; only one done pulse.
- Deassert rstn 4 cycles into SHIFT → busy=0, diff=0, no done. A new start after release gives the correct result.
